// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one i2c_controller command port between NUM_REQ requesters.
// Optional watchdog (forced STOP + timeout_irq) is built only when I2C_ARB_TIMEOUT_EN is defined.
module i2c_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [2*NUM_REQ-1:0]       req_cmd,
  input  logic [8*NUM_REQ-1:0]       req_wdata,
  input  logic [NUM_REQ-1:0]         req_wack,
  output logic [NUM_REQ-1:0]         req_accept,
  output logic [NUM_REQ-1:0]         req_done,
  output logic [NUM_REQ-1:0]         req_err,
  output logic [7:0]                 req_rdata,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       bus_held,
  output logic                       timeout_irq,
  output logic [1:0]                 ctrl_cmd,
  output logic [7:0]                 ctrl_wdata,
  output logic                       ctrl_wack,
  output logic                       ctrl_start,
  input  logic                       ctrl_ready,
  input  logic [7:0]                 ctrl_rdata
);
  localparam int OW = $clog2(NUM_REQ);
  localparam logic [1:0] CMD_START = 2'd0;
  localparam logic [1:0] CMD_READ  = 2'd2;
  localparam logic [1:0] CMD_STOP  = 2'd3;

  typedef enum logic [1:0] {ST_FREE, ST_ISSUE, ST_WAIT, ST_HELD} state_t;

  state_t             state_reg, state_next;
  logic [OW-1:0]      rr_ptr_reg, rr_ptr_next;
  logic [OW-1:0]      owner_reg, owner_next;
  logic [1:0]         cmd_reg, cmd_next;
  logic [7:0]         wdata_reg, wdata_next;
  logic               wack_reg, wack_next;
  logic [7:0]         rdata_reg, rdata_next;
  logic [NUM_REQ-1:0] done_reg, done_next;
  logic [NUM_REQ-1:0] err_reg, err_next;
  logic               win_found;
  logic [OW-1:0]      win_idx;
  logic               forced;
  logic               wd_expired;
  logic [1:0]         cmd_arr   [NUM_REQ];
  logic [7:0]         wdata_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign cmd_arr[gi]   = req_cmd[2*gi +: 2];
      assign wdata_arr[gi] = req_wdata[8*gi +: 8];
    end
  endgenerate

  function automatic logic [OW-1:0] next_idx(input logic [OW-1:0] i);
    return (i == OW'(NUM_REQ - 1)) ? '0 : i + OW'(1);
  endfunction

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    int cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr_reg) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = OW'(cand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_FREE;
      rr_ptr_reg <= '0;
      owner_reg  <= '0;
      cmd_reg    <= '0;
      wdata_reg  <= '0;
      wack_reg   <= 1'b0;
      rdata_reg  <= '0;
      done_reg   <= '0;
      err_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      owner_reg  <= owner_next;
      cmd_reg    <= cmd_next;
      wdata_reg  <= wdata_next;
      wack_reg   <= wack_next;
      rdata_reg  <= rdata_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    owner_next  = owner_reg;
    cmd_next    = cmd_reg;
    wdata_next  = wdata_reg;
    wack_next   = wack_reg;
    rdata_next  = rdata_reg;
    done_next   = '0;
    err_next    = '0;
    req_accept  = '0;
    ctrl_start  = 1'b0;
    timeout_irq = 1'b0;
    case (state_reg)
      ST_FREE: begin
        if (win_found) begin
          req_accept[win_idx] = 1'b1;
          if (cmd_arr[win_idx] == CMD_START) begin
            owner_next = win_idx;
            cmd_next   = cmd_arr[win_idx];
            wdata_next = wdata_arr[win_idx];
            wack_next  = req_wack[win_idx];
            state_next = ST_ISSUE;
          end else begin
            // Anything but START on a free bus is bounced without touching the controller.
            done_next[win_idx] = 1'b1;
            err_next[win_idx]  = 1'b1;
            rr_ptr_next        = next_idx(win_idx);
          end
        end
      end
      ST_ISSUE: begin
        ctrl_start  = 1'b1;
        timeout_irq = forced;
        state_next  = ST_WAIT;
      end
      ST_WAIT: begin
        if (ctrl_ready) begin
          if (!forced) done_next[owner_reg] = 1'b1;
          if (cmd_reg == CMD_READ) rdata_next = ctrl_rdata;
          if (cmd_reg == CMD_STOP) begin
            state_next  = ST_FREE;
            rr_ptr_next = next_idx(owner_reg);
          end else begin
            state_next = ST_HELD;
          end
        end
      end
      ST_HELD: begin
        if (req_valid[owner_reg]) begin
          req_accept[owner_reg] = 1'b1;
          cmd_next   = cmd_arr[owner_reg];
          wdata_next = wdata_arr[owner_reg];
          wack_next  = req_wack[owner_reg];
          state_next = ST_ISSUE;
        end else if (wd_expired) begin
          cmd_next   = CMD_STOP;
          state_next = ST_ISSUE;
        end
      end
      default: state_next = ST_FREE;
    endcase
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt_reg;
  logic            forced_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_reg <= '0;
      forced_reg <= 1'b0;
    end else begin
      if (state_reg != ST_HELD || req_valid[owner_reg]) wd_cnt_reg <= '0;
      else if (wd_cnt_reg != WD_MAX) wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
      if (wd_expired) forced_reg <= 1'b1;
      else if (state_reg == ST_WAIT && ctrl_ready) forced_reg <= 1'b0;
    end
  end

  // The counter holds the idle cycles already seen, so this cycle is the TIMEOUT_CYCLES-th.
  assign wd_expired = (state_reg == ST_HELD) && !req_valid[owner_reg] && (wd_cnt_reg == WD_LAST);
  assign forced     = forced_reg;
`else
  assign wd_expired = 1'b0;
  assign forced     = 1'b0;
`endif

  assign req_done   = done_reg;
  assign req_err    = err_reg;
  assign req_rdata  = rdata_reg;
  assign owner      = owner_reg;
  assign bus_held   = (state_reg != ST_FREE);
  assign ctrl_cmd   = cmd_reg;
  assign ctrl_wdata = wdata_reg;
  assign ctrl_wack  = wack_reg;
endmodule

// File: tb/tb_i2c_arbiter.sv
// Randomized bench for i2c_arbiter: three requesters and a controller model, compared every cycle
// against a transaction-level reference of the arbitration rules.
module tb_i2c_arbiter;
  localparam int N  = 3;
  localparam int TO = 20;
  localparam int OW = $clog2(N);
  localparam logic [1:0] C_START = 2'd0;
  localparam logic [1:0] C_WRITE = 2'd1;
  localparam logic [1:0] C_READ  = 2'd2;
  localparam logic [1:0] C_STOP  = 2'd3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [2*N-1:0] req_cmd;
  logic [8*N-1:0] req_wdata;
  logic [N-1:0]   req_wack;
  logic [N-1:0]   req_accept, req_done, req_err;
  logic [7:0]     req_rdata;
  logic [OW-1:0]  owner;
  logic           bus_held, timeout_irq;
  logic [1:0]     ctrl_cmd;
  logic [7:0]     ctrl_wdata;
  logic           ctrl_wack, ctrl_start;
  logic           ctrl_ready;
  logic [7:0]     ctrl_rdata;

  always #5 clk = ~clk;

  i2c_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_cmd(req_cmd), .req_wdata(req_wdata), .req_wack(req_wack),
    .req_accept(req_accept), .req_done(req_done), .req_err(req_err), .req_rdata(req_rdata),
    .owner(owner), .bus_held(bus_held), .timeout_irq(timeout_irq),
    .ctrl_cmd(ctrl_cmd), .ctrl_wdata(ctrl_wdata), .ctrl_wack(ctrl_wack), .ctrl_start(ctrl_start),
    .ctrl_ready(ctrl_ready), .ctrl_rdata(ctrl_rdata)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: transaction view of the bus.
  bit         m_open;
  int         m_own, m_rr, m_phase, m_idle;
  bit         m_forced;
  logic [1:0] m_cmd;
  logic [7:0] m_wdata, m_rdata;
  logic       m_wack;
  logic [N-1:0] m_done, m_err;

  // Requester and controller stimulus state.
  bit         r_wait [N];
  bit         r_own  [N];
  bit         r_first[N];
  bit         acc_last[N];
  int         r_gap  [N];
  logic [1:0] r_cmd  [N];
  int         c_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic string cname(input logic [1:0] c);
    case (c)
      C_START: return "START";
      C_WRITE: return "WRITE";
      C_READ:  return "READ";
      default: return "STOP";
    endcase
  endfunction

  // Requester with the smallest round-robin distance from m_rr.
  function automatic int pick(input logic [N-1:0] v);
    int best, bestd, d;
    best = -1; bestd = N;
    for (int i = 0; i < N; i++) begin
      d = (i - m_rr + N) % N;
      if (v[i] && d < bestd) begin
        bestd = d;
        best  = i;
      end
    end
    return best;
  endfunction

  function automatic int owner_gap();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 70) return int'($urandom_range(0, 2));
    if (r < 90) return int'($urandom_range(3, 10));
    return int'($urandom_range(18, 24));
  endfunction

  task automatic model_reset();
    m_open = 0; m_own = 0; m_rr = 0; m_phase = 0; m_idle = 0; m_forced = 0;
    m_cmd = '0; m_wdata = '0; m_wack = 1'b0; m_rdata = '0; m_done = '0; m_err = '0;
  endtask

  task automatic drive_req(input int i);
    logic [1:0] c;
    int r;
    if (acc_last[i]) begin
      req_valid[i] = 1'b0;
      r_wait[i]    = 1;
    end
    if (timeout_irq && int'(owner) == i) r_own[i] = 0;
    if (r_wait[i] && req_done[i]) begin
      r_wait[i] = 0;
      if (req_err[i]) r_own[i] = 0;
      else if (r_cmd[i] == C_START) r_own[i] = 1;
      else if (r_cmd[i] == C_STOP) r_own[i] = 0;
      r_gap[i] = r_own[i] ? owner_gap() : int'($urandom_range(0, 12));
    end
    if (!r_wait[i] && !req_valid[i]) begin
      if (r_gap[i] > 0) r_gap[i]--;
      else begin
        r = int'($urandom_range(0, 99));
        if (r_own[i]) c = (r < 10) ? C_START : (r < 45) ? C_WRITE : (r < 75) ? C_READ : C_STOP;
        else if (r_first[i] || r >= 12) c = C_START;
        else c = 2'($urandom_range(1, 3));
        r_first[i] = 0;
        r_cmd[i]   = c;
        req_valid[i]          = 1'b1;
        req_cmd[2*i +: 2]     = c;
        req_wdata[8*i +: 8]   = 8'($urandom);
        req_wack[i]           = 1'($urandom);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0; req_cmd = '0; req_wdata = '0; req_wack = '0;
    ctrl_ready = 1'b1; ctrl_rdata = '0; c_busy = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_accept", 32'(req_accept), 32'd0);
    check("rst_done", 32'(req_done), 32'd0);
    check("rst_err", 32'(req_err), 32'd0);
    check("rst_rdata", 32'(req_rdata), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_bus_held", 32'(bus_held), 32'd0);
    check("rst_irq", 32'(timeout_irq), 32'd0);
    check("rst_ctrl_start", 32'(ctrl_start), 32'd0);
    check("rst_ctrl_cmd", 32'(ctrl_cmd), 32'd0);
    check("rst_ctrl_wdata", 32'(ctrl_wdata), 32'd0);
    check("rst_ctrl_wack", 32'(ctrl_wack), 32'd0);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < N; i++) begin
      r_wait[i] = 0; r_own[i] = 0; r_first[i] = 1; acc_last[i] = 0; r_gap[i] = 0; r_cmd[i] = '0;
    end
  endtask

  task automatic run(input int ncyc);
    int w;
    logic [N-1:0] exp_acc, nd, ne;
    logic [1:0] c;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      cyc++;
      if (c_busy > 0) begin
        c_busy--;
        if (c_busy == 0) begin
          ctrl_ready = 1'b1;
          ctrl_rdata = 8'($urandom);
        end
      end
      for (int i = 0; i < N; i++) drive_req(i);
      #1;
      w = -1;
      if (m_phase == 0) begin
        if (!m_open) w = pick(req_valid);
        else if (req_valid[m_own]) w = m_own;
      end
      exp_acc = '0;
      if (w >= 0) exp_acc[w] = 1'b1;
      check("accept", 32'(req_accept), 32'(exp_acc));
      check("done", 32'(req_done), 32'(m_done));
      check("err", 32'(req_err), 32'(m_err));
      check("rdata", 32'(req_rdata), 32'(m_rdata));
      check("owner", 32'(owner), 32'(m_own));
      check("bus_held", 32'(bus_held), 32'(m_open));
      check("ctrl_start", 32'(ctrl_start), 32'(m_phase == 1));
      check("timeout_irq", 32'(timeout_irq), 32'(m_phase == 1 && m_forced));
      if (m_phase == 1) begin
        check("ctrl_cmd", 32'(ctrl_cmd), 32'(m_cmd));
        if (!m_forced) begin
          check("ctrl_wdata", 32'(ctrl_wdata), 32'(m_wdata));
          check("ctrl_wack", 32'(ctrl_wack), 32'(m_wack));
        end
      end
      for (int i = 0; i < N; i++) acc_last[i] = req_accept[i];

      nd = '0; ne = '0;
      case (m_phase)
        0: begin
          if (w >= 0) begin
            c = req_cmd[2*w +: 2];
            if (m_open || c == C_START) begin
              if (!m_open) begin
                m_open = 1;
                m_own  = w;
              end
              m_cmd = c; m_wdata = req_wdata[8*w +: 8]; m_wack = req_wack[w];
              m_phase = 1; m_idle = 0;
            end else begin
              nd[w] = 1'b1; ne[w] = 1'b1;
              m_rr = (w + 1) % N;
              $display("cyc %0d req%0d %s rejected on free bus", cyc, w, cname(c));
            end
          end else if (m_open) begin
`ifdef I2C_ARB_TIMEOUT_EN
            m_idle++;
            if (m_idle == TO) begin
              m_forced = 1; m_cmd = C_STOP; m_phase = 1; m_idle = 0;
              $display("cyc %0d watchdog closes transaction of req%0d", cyc, m_own);
            end
`endif
          end
        end
        1: m_phase = 2;
        default: begin
          if (ctrl_ready) begin
            if (m_cmd == C_READ) m_rdata = ctrl_rdata;
            if (!m_forced) begin
              nd[m_own] = 1'b1;
              $display("cyc %0d req%0d %s done wdata=%02h rdata=%02h", cyc, m_own, cname(m_cmd), m_wdata, m_rdata);
            end
            if (m_cmd == C_STOP) begin
              m_open = 0;
              m_rr   = (m_own + 1) % N;
            end
            m_forced = 0; m_phase = 0; m_idle = 0;
          end
        end
      endcase
      m_done = nd; m_err = ne;

      if (ctrl_start) begin
        ctrl_ready = 1'b0;
        c_busy     = int'($urandom_range(2, 9));
      end
    end
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    do_reset();
    run(1500);
    guard = 0;
    while (m_phase != 2 && guard < 200) begin
      run(1);
      guard++;
    end
    check("midreset_reach_wait", 32'(m_phase == 2), 32'd1);
    do_reset();
    run(1500);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
